uart_rx_framer: RTL and testbench
=================================

# uart_rx_framer

Serial-to-parallel UART receive framer placed directly downstream of the two-flop `syncronizer`. It consumes the already-synchronized RX line, detects and validates start bits, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each received byte is presented on a valid/ready output port. Framing, parity and overrun conditions are flagged with single-cycle error pulses.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per serial bit (100 MHz / 115200); must be ≥ 4; `H = CLKS_PER_BIT/2` (integer division).
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `reset` input, 1 bit: **synchronous, active-high** reset.
- `rx_sync` input, 1 bit: synchronized serial line from `syncronizer.data_out`; idles high.
- `rx_data` output, 8 bits: received byte; stable while `rx_valid` is high.
- `rx_valid` output, 1 bit: byte available; held until accepted.
- `rx_ready` input, 1 bit: consumer accepts when `rx_valid && rx_ready`.
- `frame_err` output, 1 bit: 1-cycle pulse when the stop bit is sampled low.
- `parity_err` output, 1 bit: 1-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
- `overrun` output, 1 bit: 1-cycle pulse when a completed byte is dropped.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: the first cycle with `rx_sync==0` is T0. Go to START with the bit timer cleared.
- START: sample at T0+H.
  - Low: go to DATA with the bit index at 0.
  - High: treat as a glitch and return to IDLE with no flags.
- DATA: data bit i (i = 0..7) is sampled at T0+H+(i+1)·CLKS_PER_BIT and shifted in LSB-first. After bit 7, go to PARITY or STOP.
- PARITY: sampled at T0+H+9·CLKS_PER_BIT; the parity check is described under Configuration.
- STOP: sampled one bit period after the last data or parity sample.
  - High, parity OK: deliver the byte and go to IDLE.
  - Low: pulse `frame_err`, drop the byte, go to BREAK.
- BREAK: wait until `rx_sync==1`, then go to IDLE. A held-low line produces exactly one `frame_err`.
- Delivery:
  - `rx_valid` low: load `rx_data` and set `rx_valid`.
  - `rx_valid` high and accepted in the same cycle: load the new byte and keep `rx_valid` high. No overrun.
  - `rx_valid` high and not accepted: keep the old byte, pulse `overrun`, drop the new byte.
- Acceptance (`rx_valid && rx_ready`) with no new byte in the same cycle clears `rx_valid` on the next edge.
- Receive FSM runs independently of `rx_ready`; backpressure never stalls sampling.

## Timing
- Reset values: state IDLE, `rx_data=8'h00`, `rx_valid=0`, `frame_err=0`, `parity_err=0`, `overrun=0`, timer and bit index 0.
- Reset asserted mid-frame abandons the frame with no flags. IDLE is entered on the cycle after reset deasserts.
- Latency: `rx_valid` rises on the edge after the stop sample.
  - Without parity: high from cycle T0+H+9·CLKS_PER_BIT+1.
  - With parity: high from cycle T0+H+10·CLKS_PER_BIT+1.
  - All error pulses align with that same cycle.
- Bit timer width: `$clog2(CLKS_PER_BIT)`. The timer wraps to 0 at each sample point, with no drift.
- A new start bit is detected as soon as IDLE is re-entered. There is no dead cycle beyond the IDLE check.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state and an even-parity bit after data bit 7.
  - On mismatch, the byte is dropped and `parity_err` pulses when the stop bit is sampled (even if the stop bit is good).
  - If the stop bit is also low, both `frame_err` and `parity_err` pulse.
- Undefined: frame is 8N1, no PARITY state, `parity_err` tied to 0.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum.
  - `UART_DATA_BITS = 8`.
  - Even-parity function, shared with the future transmitter.
- One sub-module, `uart_bit_timer`: counter with clear input; produces the half-bit pulse and the full-bit pulses.
- The FSM, shift register and output register live in `uart_rx_framer`.

## Test plan
All scenarios use `CLKS_PER_BIT=16`, `H=8`, and no parity unless stated.
- Frame `0xA5` with `rx_ready=1` → `rx_data=8'hA5`; `rx_valid` high exactly at T0+153 for one cycle; no flags.
- Line low for 4 cycles, then high → stays in IDLE; no `rx_valid`, no flags.
- Frame `0x5A` with the stop bit low, then line held low for 40 cycles → one `frame_err` pulse at T0+153, no `rx_valid`; a following `0x11` frame is received correctly.
- Frames `0x3C` then `0xC3` back-to-back with `rx_ready=0` → `rx_data` stays `8'h3C`; `overrun` pulses once at the end of the second frame; raising `rx_ready` clears `rx_valid` next cycle.
- `UART_RX_PARITY_EN` defined, frame `0x07` with parity bit 0 (wrong) → `parity_err` pulse at T0+169, no `rx_valid`; the same frame with parity bit 1 → `rx_data=8'h07`.
- `reset` pulsed at data bit 4 of a `0xFF` frame → all outputs at reset values; the next `0x81` frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// even-parity helper used by both receive and transmit paths.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_t;

  // Parity bit that makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver: a free-running counter with a
// clear input, flagging the half-bit and full-bit sample points.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_r;

  // Counter restarts from zero whenever the framer consumes a sample point.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + 1'b1;
    end
  end

  assign half_tick = (count_r == HALF_LAST);
  assign full_tick = (count_r == FULL_LAST);

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: start validation, mid-bit sampling, stop/parity check
// and valid/ready byte delivery. Optional even parity via UART_RX_PARITY_EN.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_sync,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_rx_state_t            state_r;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic [IDX_W-1:0]          bit_idx_r;
  logic                      half_tick_s;
  logic                      full_tick_s;
  logic                      timer_clear_s;
  logic                      byte_bad_s;

`ifdef UART_RX_PARITY_EN
  logic parity_bad_r;
  assign byte_bad_s = parity_bad_r;
`else
  assign byte_bad_s = 1'b0;
`endif

  // Timer restarts on start-bit detection and at every consumed sample point.
  assign timer_clear_s = (state_r == ST_IDLE)  ? ~rx_sync    :
                         (state_r == ST_START) ? half_tick_s : full_tick_s;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear_s),
    .half_tick (half_tick_s),
    .full_tick (full_tick_s)
  );

  // Receive FSM, shift register and output holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      bit_idx_r  <= '0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_r <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (half_tick_s) begin
            if (!rx_sync) begin
              state_r   <= ST_DATA;
              bit_idx_r <= '0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (full_tick_s) begin
            shift_r   <= {rx_sync, shift_r[UART_DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + 1'b1;
            if (bit_idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (full_tick_s) begin
            parity_bad_r <= (rx_sync != even_parity(shift_r));
            state_r      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (full_tick_s) begin
`ifdef UART_RX_PARITY_EN
            parity_err <= parity_bad_r;
`endif
            if (!rx_sync) begin
              frame_err <= 1'b1;
              state_r   <= ST_BREAK;
            end else begin
              state_r <= ST_IDLE;
              // A pending byte accepted this same cycle frees the slot.
              if (!byte_bad_s) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shift_r;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end
          end
        end
        ST_BREAK: begin
          if (rx_sync) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer (CLKS_PER_BIT=16): directed scenarios
// plus random frames scored against a frame-level timing/outcome model.
module tb_uart_rx_framer;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NSAMP = 10;
`else
  localparam int NSAMP = 9;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_sync;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  uart_rx_framer #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_sync    (rx_sync),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } ev_t;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic prev_acc = 1'b0;
  logic mdl_pending = 1'b0;
  ev_t  mon_ev;

  ev_t dlv_q[$];
  ev_t exp_dlv_q[$];
  int  fe_q[$], pe_q[$], ov_q[$];
  int  exp_fe_q[$], exp_pe_q[$], exp_ov_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observed-event monitor: new byte presentations and error pulses, stamped with edge index.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      if (rx_valid && (!prev_valid || prev_acc)) begin
        mon_ev.cyc  = cyc;
        mon_ev.data = rx_data;
        dlv_q.push_back(mon_ev);
      end
      if (rx_valid)   valid_cycles++;
      if (frame_err)  fe_q.push_back(cyc);
      if (parity_err) pe_q.push_back(cyc);
      if (overrun)    ov_q.push_back(cyc);
      prev_valid = rx_valid;
      prev_acc   = rx_valid && rx_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input int obs[$], input int exp[$]);
    check({tag, ".count"}, obs.size(), exp.size());
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      check({tag, ".cycle"}, obs[i], exp[i]);
    end
  endtask

  task automatic check_events(input string tag);
    check({tag, ".dlv.count"}, dlv_q.size(), exp_dlv_q.size());
    for (int i = 0; i < dlv_q.size() && i < exp_dlv_q.size(); i++) begin
      check({tag, ".dlv.cycle"}, dlv_q[i].cyc, exp_dlv_q[i].cyc);
      check({tag, ".dlv.data"}, {24'h0, dlv_q[i].data}, {24'h0, exp_dlv_q[i].data});
    end
    cmp_q({tag, ".frame_err"}, fe_q, exp_fe_q);
    cmp_q({tag, ".parity_err"}, pe_q, exp_pe_q);
    cmp_q({tag, ".overrun"}, ov_q, exp_ov_q);
    dlv_q.delete(); exp_dlv_q.delete();
    fe_q.delete();  exp_fe_q.delete();
    pe_q.delete();  exp_pe_q.delete();
    ov_q.delete();  exp_ov_q.delete();
  endtask

  // Drives start, 8 data bits LSB-first, optional parity and stop; t0 is the edge that first sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, output int t0);
    rx_sync = 1'b0;
    t0 = cyc + 1;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rx_sync = b[i];
      wait_cycles(C);
    end
`ifdef UART_RX_PARITY_EN
    rx_sync = par;
    wait_cycles(C);
`endif
    rx_sync = stp;
    wait_cycles(C);
    rx_sync = 1'b1;
  endtask

  // Frame-level reference: outcome and cycle of the stop-bit decision.
  task automatic expect_frame(input logic [7:0] b, input logic par, input logic stp, input int t0);
    int   k;
    logic par_ok;
    ev_t  e;
    k = t0 + H + NSAMP * C;
`ifdef UART_RX_PARITY_EN
    par_ok = (par == ^b);
`else
    par_ok = 1'b1;
`endif
    if (!stp)    exp_fe_q.push_back(k);
    if (!par_ok) exp_pe_q.push_back(k);
    if (stp && par_ok) begin
      if (mdl_pending) begin
        exp_ov_q.push_back(k);
      end else begin
        e.cyc  = k;
        e.data = b;
        exp_dlv_q.push_back(e);
        if (!rx_ready) mdl_pending = 1'b1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_data"},    {24'h0, rx_data}, 32'h0000_0000);
    check({tag, ".rx_valid"},   {31'h0, rx_valid}, 32'h0000_0000);
    check({tag, ".frame_err"},  {31'h0, frame_err}, 32'h0000_0000);
    check({tag, ".parity_err"}, {31'h0, parity_err}, 32'h0000_0000);
    check({tag, ".overrun"},    {31'h0, overrun}, 32'h0000_0000);
  endtask

  initial begin
    int         t0;
    int         vc0;
    logic [7:0] b;
    logic       stp;
    logic       par;
    int         gap;

    reset    = 1'b1;
    rx_sync  = 1'b1;
    rx_ready = 1'b1;
    wait_cycles(4);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_cycles(3);

    // Single good frame, consumer always ready: one-cycle rx_valid.
    vc0 = valid_cycles;
    send_frame(8'hA5, ^(8'hA5), 1'b1, t0);
    expect_frame(8'hA5, ^(8'hA5), 1'b1, t0);
    wait_cycles(4);
    check_events("a5");
    check("a5.valid_width", valid_cycles - vc0, 32'd1);

    // Short low glitch must not start a frame.
    rx_sync = 1'b0;
    wait_cycles(4);
    rx_sync = 1'b1;
    wait_cycles(40);
    check_events("glitch");

    // Bad stop bit followed by a held-low line, then recovery.
    send_frame(8'h5A, ^(8'h5A), 1'b0, t0);
    expect_frame(8'h5A, ^(8'h5A), 1'b0, t0);
    rx_sync = 1'b0;
    wait_cycles(40);
    rx_sync = 1'b1;
    wait_cycles(5);
    send_frame(8'h11, ^(8'h11), 1'b1, t0);
    expect_frame(8'h11, ^(8'h11), 1'b1, t0);
    wait_cycles(4);
    check_events("break");

    // Back-to-back frames against a stalled consumer.
    rx_ready = 1'b0;
    send_frame(8'h3C, ^(8'h3C), 1'b1, t0);
    expect_frame(8'h3C, ^(8'h3C), 1'b1, t0);
    send_frame(8'hC3, ^(8'hC3), 1'b1, t0);
    expect_frame(8'hC3, ^(8'hC3), 1'b1, t0);
    wait_cycles(4);
    check_events("overrun");
    check("overrun.rx_data", {24'h0, rx_data}, 32'h0000_003C);
    check("overrun.rx_valid", {31'h0, rx_valid}, 32'h0000_0001);
    rx_ready = 1'b1;
    mdl_pending = 1'b0;
    wait_cycles(1);
    check("overrun.accept", {31'h0, rx_valid}, 32'h0000_0000);
    wait_cycles(3);

`ifdef UART_RX_PARITY_EN
    // Wrong then correct even-parity bit.
    send_frame(8'h07, 1'b0, 1'b1, t0);
    expect_frame(8'h07, 1'b0, 1'b1, t0);
    wait_cycles(3);
    send_frame(8'h07, 1'b1, 1'b1, t0);
    expect_frame(8'h07, 1'b1, 1'b1, t0);
    wait_cycles(4);
    check_events("parity");
`endif

    // Reset in the middle of a frame while a byte is still held.
    rx_ready = 1'b0;
    send_frame(8'h42, ^(8'h42), 1'b1, t0);
    expect_frame(8'h42, ^(8'h42), 1'b1, t0);
    wait_cycles(3);
    check_events("prereset");
    rx_sync = 1'b0;
    wait_cycles(C);
    rx_sync = 1'b1;
    wait_cycles(4 * C + 3);
    reset = 1'b1;
    wait_cycles(2);
    check_reset_outputs("midreset");
    reset = 1'b0;
    rx_ready = 1'b1;
    mdl_pending = 1'b0;
    wait_cycles(6 * C);
    check_events("midreset");
    send_frame(8'h81, ^(8'h81), 1'b1, t0);
    expect_frame(8'h81, ^(8'h81), 1'b1, t0);
    wait_cycles(4);
    check_events("after_reset");

    // Random frames with random backpressure, stop and parity errors.
    for (int n = 0; n < 40; n++) begin
      b   = 8'($urandom);
      stp = ($urandom_range(0, 7) != 0);
      par = ^b;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 7) == 0) par = ~par;
`endif
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_ready) mdl_pending = 1'b0;
      send_frame(b, par, stp, t0);
      expect_frame(b, par, stp, t0);
      check_events("random");
      gap = stp ? $urandom_range(0, 4) : $urandom_range(2, 6);
      if (gap > 0) wait_cycles(gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
